time_entry_countdown: RTL and testbench

TIME_ENTRY_COUNTDOWN -- requirements
Module: time_entry_countdown

---
 rtl/time_entry_countdown.sv | 123 ++++++++++++
 tb/tb_time_entry_countdown.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry_countdown.sv
// Keypad time entry and BCD countdown (M:SS) for an appliance timer.
// Digits shift in from the right, are normalized on start, then count down once per tick.
module time_entry_countdown #(
  parameter int unsigned MAX_MINS = 9
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] data_in,
  input  logic       loadn,
  input  logic       tick_1hz,
  input  logic       enable,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       zero,
  output logic       done,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] MAX_MINS_D = 4'(MAX_MINS);

  logic [1:0] state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] mins_q, mins_d;
  logic       loadn_q;
  logic       done_q, done_d;
  logic       busy_q;
  logic       strobe;
  logic       digit_ok;

  assign strobe   = loadn_q & ~loadn;
  assign digit_ok = (data_in <= 4'd9);
  assign zero     = ((mins_q | tens_q | ones_q) == 4'd0);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    mins_d  = mins_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (strobe && digit_ok) begin
          mins_d  = tens_q;
          tens_d  = ones_q;
          ones_d  = data_in;
          state_d = S_ENTRY;
        end else if (state_q == S_ENTRY && enable && !zero) begin
          state_d = S_COUNT;
          // Entries like 0:90 are folded into 1:30 before counting starts.
          if (tens_q > 4'd5) begin
            tens_d = tens_q - 4'd6;
            mins_d = (mins_q >= MAX_MINS_D) ? MAX_MINS_D : mins_q + 4'd1;
          end
        end
      end

      S_COUNT: begin
        if (enable && tick_1hz) begin
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            if (tens_q != 4'd0) begin
              tens_d = tens_q - 4'd1;
            end else begin
              tens_d = 4'd5;
              mins_d = mins_q - 4'd1;
            end
          end
          if ({mins_d, tens_d, ones_d} == 12'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values present before the edge.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q <= S_IDLE;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      mins_q  <= 4'd0;
      loadn_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      mins_q  <= mins_d;
      loadn_q <= loadn;
      done_q  <= done_d;
      busy_q  <= (state_d == S_COUNT);
    end
  end

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign mins     = mins_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_time_entry_countdown.sv
// Self-checking bench for time_entry_countdown: directed scenarios then random
// keypad/enable/tick traffic, compared against a seconds-based reference model.
module tb_time_entry_countdown;

  localparam int MAX_MINS = 9;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_COUNT = 2, M_DONE = 3;

  logic       clock = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       loadn = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] sec_ones, sec_tens, mins;
  logic       zero, done, busy;

  int checks = 0;
  int errors = 0;
  int done_seen;

  int m_mode, m_ones, m_tens, m_mins;
  bit m_done, m_prev;

  time_entry_countdown #(.MAX_MINS(MAX_MINS)) dut (
    .clock    (clock),
    .clearn   (clearn),
    .data_in  (data_in),
    .loadn    (loadn),
    .tick_1hz (tick_1hz),
    .enable   (enable),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .mins     (mins),
    .zero     (zero),
    .done     (done),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_ones = 0;
    m_tens = 0;
    m_mins = 0;
    m_done = 0;
    m_prev = 1;
  endtask

  // Reference: entered digits are kept as raw digits; counting works on total seconds.
  task automatic model_update();
    bit strobe;
    int secs;
    strobe = m_prev && !loadn;
    m_done = 0;
    if ((m_mode == M_IDLE || m_mode == M_ENTRY) && strobe && data_in <= 4'd9) begin
      m_mins = m_tens;
      m_tens = m_ones;
      m_ones = int'(data_in);
      m_mode = M_ENTRY;
    end else if (m_mode == M_ENTRY && enable && (m_mins + m_tens + m_ones) != 0) begin
      if (m_tens > 5) begin
        secs   = m_tens * 10 + m_ones;
        m_mins = m_mins + secs / 60;
        if (m_mins > MAX_MINS) m_mins = MAX_MINS;
        secs   = secs % 60;
        m_tens = secs / 10;
        m_ones = secs % 10;
      end
      m_mode = M_COUNT;
    end else if (m_mode == M_COUNT && enable && tick_1hz) begin
      secs   = m_mins * 60 + m_tens * 10 + m_ones - 1;
      m_mins = secs / 60;
      m_tens = (secs % 60) / 10;
      m_ones = secs % 10;
      if (secs == 0) begin
        m_mode = M_DONE;
        m_done = 1;
      end
    end else if (m_mode == M_DONE && !enable) begin
      m_mode = M_IDLE;
    end
    m_prev = loadn;
  endtask

  task automatic compare_all();
    check("sec_ones", 32'(sec_ones), 32'(m_ones));
    check("sec_tens", 32'(sec_tens), 32'(m_tens));
    check("mins",     32'(mins),     32'(m_mins));
    check("zero",     32'(zero),     32'((m_mins + m_tens + m_ones) == 0));
    check("done",     32'(done),     32'(m_done));
    check("busy",     32'(busy),     32'(m_mode == M_COUNT));
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic strobe_digit(input logic [3:0] d);
    data_in = d;
    loadn = 1'b0;
    step();
    step();
    loadn = 1'b1;
    step();
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #3;
    clearn = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_disp", 32'({mins, sec_tens, sec_ones}), 32'h000);
    loadn = 1'b1;
    tick_1hz = 1'b0;
    enable = 1'b0;
    @(posedge clock);
    #1;
    compare_all();
    @(negedge clock);
    clearn = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all();
    check("init_disp", 32'({mins, sec_tens, sec_ones}), 32'h000);
    @(negedge clock);
    clearn = 1'b1;

    // Enter 1:30 and count it all the way down.
    strobe_digit(4'd1);
    strobe_digit(4'd3);
    strobe_digit(4'd0);
    check("entry_130", 32'({mins, sec_tens, sec_ones}), 32'h130);
    enable = 1'b1;
    step();
    check("start_busy", 32'(busy), 32'd1);
    done_seen = 0;
    for (int i = 0; i < 130; i++) begin
      tick_1hz = 1'b1;
      step();
      if (i == 0) check("first_tick", 32'({mins, sec_tens, sec_ones}), 32'h129);
      if (i == 30) check("min_borrow", 32'({mins, sec_tens, sec_ones}), 32'h059);
      done_seen += int'(done);
      tick_1hz = 1'b0;
      step();
      done_seen += int'(done);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      done_seen += int'(done);
    end
    check("done_once", 32'(done_seen), 32'd1);
    check("end_disp", 32'({mins, sec_tens, sec_ones}), 32'h000);
    enable = 1'b0;
    step();

    // Enabling with 0:00 entered must not start a countdown.
    strobe_digit(4'd0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("zero_nobusy", 32'(busy), 32'd0);
    enable = 1'b0;
    step();

    // Four digits keep only the last three; non-BCD codes are ignored.
    strobe_digit(4'd1);
    strobe_digit(4'd2);
    strobe_digit(4'd3);
    strobe_digit(4'd4);
    check("entry_234", 32'({mins, sec_tens, sec_ones}), 32'h234);
    strobe_digit(4'hC);
    check("bad_digit", 32'({mins, sec_tens, sec_ones}), 32'h234);

    // Normalization on start; a tick coinciding with start is ignored.
    apply_reset();
    strobe_digit(4'd9);
    strobe_digit(4'd0);
    enable = 1'b1;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    check("norm_130", 32'({mins, sec_tens, sec_ones}), 32'h130);
    apply_reset();
    strobe_digit(4'd9);
    strobe_digit(4'd9);
    strobe_digit(4'd9);
    enable = 1'b1;
    step();
    check("norm_sat", 32'({mins, sec_tens, sec_ones}), 32'h939);

    // Pause at 1:00, resume, ignore strobes mid-count.
    apply_reset();
    strobe_digit(4'd1);
    strobe_digit(4'd0);
    strobe_digit(4'd0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      step();
    end
    check("pause_hold", 32'({mins, sec_tens, sec_ones}), 32'h100);
    enable = 1'b1;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    check("resume_059", 32'({mins, sec_tens, sec_ones}), 32'h059);
    strobe_digit(4'd7);
    check("count_strobe", 32'({mins, sec_tens, sec_ones}), 32'h059);
    for (int i = 0; i < 70 && m_mode == M_COUNT; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      step();
    end
    enable = 1'b0;
    step();

    // Reset during a countdown aborts it with no done pulse.
    strobe_digit(4'd5);
    enable = 1'b1;
    step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    apply_reset();
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) step();

    // Random keypad, enable and tick traffic.
    for (int c = 0; c < 4000; c++) begin
      if (c % 700 == 699) apply_reset();
      if (loadn) begin
        if ($urandom_range(3) == 0) begin
          data_in = 4'($urandom_range(15));
          loadn = 1'b0;
        end
      end else if ($urandom_range(1) == 0) begin
        loadn = 1'b1;
      end
      if ($urandom_range(24) == 0) enable = ~enable;
      tick_1hz = ($urandom_range(2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
